// File: rtl/energy_accumulator.sv
// energy_accumulator: sums DATASPIN signed local energies per run into a total and tracks the lowest total with its spin vector
module energy_accumulator #(
  parameter int DATASPIN = 256,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int TOTAL_ENERGY_BIT = LOCAL_ENERGY_BIT + $clog2(DATASPIN)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [DATASPIN-1:0]                spin_i,
  input  logic                               clear_best_i,
  input  logic                               energy_valid_i,
  output logic                               energy_ready_o,
  input  logic signed [LOCAL_ENERGY_BIT-1:0] energy_i,
  output logic                               total_valid_o,
  input  logic                               total_ready_i,
  output logic signed [TOTAL_ENERGY_BIT-1:0] total_energy_o,
  output logic                               improved_o,
  output logic                               best_valid_o,
  output logic signed [TOTAL_ENERGY_BIT-1:0] best_energy_o,
  output logic [DATASPIN-1:0]                best_spin_o,
  output logic                               busy_o
);
  localparam int CW = DATASPIN > 1 ? $clog2(DATASPIN) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [DATASPIN-1:0] spin_reg;
  logic signed [TOTAL_ENERGY_BIT-1:0] acc, sum;
  logic fire, last, better;
  assign energy_ready_o = state == ACCUM;
  assign total_valid_o = state == OUTPUT;
  assign busy_o = state != IDLE;
  assign fire = energy_valid_i && energy_ready_o;
  assign last = cnt == CW'(DATASPIN - 1);
  assign sum = acc + TOTAL_ENERGY_BIT'(energy_i);
  assign better = !best_valid_o || sum < best_energy_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      spin_reg <= '0;
      total_energy_o <= '0;
      improved_o <= 1'b0;
      best_valid_o <= 1'b0;
      best_energy_o <= '0;
      best_spin_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          acc <= '0;
          cnt <= '0;
          spin_reg <= spin_i;
          state <= ACCUM;
        end
        ACCUM: if (fire) begin
          acc <= sum;
          cnt <= cnt + CW'(1);
          if (last) begin
            total_energy_o <= sum;
            improved_o <= better;
            state <= OUTPUT;
            if (better) begin
              best_valid_o <= 1'b1;
              best_energy_o <= sum;
              best_spin_o <= spin_reg;
            end
          end
        end
        OUTPUT: if (total_ready_i) begin
          improved_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (clear_best_i) begin
        best_valid_o <= 1'b0;
        best_energy_o <= '0;
        best_spin_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_energy_accumulator.sv
// tb_energy_accumulator: randomized self-checking bench against a sum/min reference model
module tb_energy_accumulator;
  logic clk = 0, rst = 1, start = 0, clear_best = 0, energy_valid = 0, total_ready = 0;
  logic [3:0] spin = 0;
  logic signed [7:0] energy = 0;
  logic energy_ready, total_valid, improved, best_valid, busy;
  logic signed [9:0] total_energy, best_energy;
  logic [3:0] best_spin;
  int total = 0, bad = 0;
  bit m_bv = 0;
  int m_be = 0;
  logic [3:0] m_bs = 0;
  always #5 clk = ~clk;
  energy_accumulator #(.DATASPIN(4), .LOCAL_ENERGY_BIT(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .spin_i(spin), .clear_best_i(clear_best),
    .energy_valid_i(energy_valid), .energy_ready_o(energy_ready), .energy_i(energy),
    .total_valid_o(total_valid), .total_ready_i(total_ready), .total_energy_o(total_energy),
    .improved_o(improved), .best_valid_o(best_valid), .best_energy_o(best_energy),
    .best_spin_o(best_spin), .busy_o(busy)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_best();
    chk("best_valid", best_valid, m_bv);
    chk("best_energy", best_energy, m_be);
    chk("best_spin", best_spin, m_bs);
  endtask
  task automatic chk_idle();
    chk("idle_busy", busy, 0);
    chk("idle_ready", energy_ready, 0);
    chk("idle_tvalid", total_valid, 0);
    chk("idle_improved", improved, 0);
  endtask
  task automatic do_run(input logic [3:0] sp, input int e[4], input int gap_pct,
                        input int stall, input bit clr_last);
    int sum = 0;
    bit imp;
    start = 1;
    spin = sp;
    @(negedge clk);
    start = 0;
    spin = ~sp;
    chk("run_busy", busy, 1);
    chk("run_ready", energy_ready, 1);
    for (int i = 0; i < 4; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        energy_valid = 0;
        energy = 8'($urandom);
        @(negedge clk);
        if (total_valid) chk("gap_no_total", total_valid, 0);
      end
      energy_valid = 1;
      energy = 8'(e[i]);
      sum += e[i];
      clear_best = clr_last && i == 3;
      @(negedge clk);
      energy_valid = 0;
      clear_best = 0;
    end
    imp = !m_bv || sum < m_be;
    if (imp) begin
      m_bv = 1;
      m_be = sum;
      m_bs = sp;
    end
    if (clr_last) begin
      m_bv = 0;
      m_be = 0;
      m_bs = 0;
    end
    chk("total_valid", total_valid, 1);
    chk("total_energy", total_energy, sum);
    chk("improved", improved, imp);
    chk("out_ready", energy_ready, 0);
    chk_best();
    for (int s = 0; s < stall; s++) begin
      energy_valid = 1;
      energy = 8'($urandom);
      start = s[0];
      @(negedge clk);
      chk("stall_valid", total_valid, 1);
      chk("stall_total", total_energy, sum);
      chk("stall_improved", improved, imp);
      chk("stall_ready", energy_ready, 0);
    end
    energy_valid = 0;
    total_ready = 1;
    start = stall > 0;
    @(negedge clk);
    total_ready = 0;
    start = 0;
    chk_idle();
    chk_best();
  endtask
  initial begin
    int e[4];
    repeat (2) @(negedge clk);
    chk_idle();
    chk("rst_total", total_energy, 0);
    chk_best();
    rst = 0;
    @(negedge clk);
    do_run(4'b1010, '{10, -3, 5, -20}, 0, 0, 0);
    do_run(4'b0110, '{1, 1, 1, 1}, 0, 0, 0);
    do_run(4'b0001, '{-2, -2, -2, -2}, 0, 0, 0);
    do_run(4'b0011, '{5, -7, 9, -1}, 50, 5, 0);
    do_run(4'b1111, '{-128, -128, -128, -128}, 0, 0, 0);
    do_run(4'b0101, '{127, 127, 127, 127}, 0, 2, 0);
    start = 1;
    spin = 4'b1001;
    @(negedge clk);
    start = 0;
    energy_valid = 1;
    energy = 3;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    energy_valid = 0;
    m_bv = 0;
    m_be = 0;
    m_bs = 0;
    chk_idle();
    chk("midrst_total", total_energy, 0);
    chk_best();
    @(negedge clk);
    chk("midrst_stays_idle", busy, 0);
    do_run(4'b1100, '{2, 2, 2, 2}, 0, 0, 0);
    do_run(4'b0111, '{-20, -10, -15, -5}, 0, 0, 1);
    clear_best = 1;
    @(negedge clk);
    clear_best = 0;
    do_run(4'b1000, '{9, 0, 0, 0}, 0, 0, 0);
    clear_best = 1;
    @(negedge clk);
    clear_best = 0;
    m_bv = 0;
    m_be = 0;
    m_bs = 0;
    chk_best();
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) e[i] = int'($signed(8'($urandom)));
      do_run(4'($urandom), e, 30, $urandom_range(3), $urandom_range(9) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
